// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor: direct-mapped BTB with a 2-bit saturating direction counter per entry.
// Optional resolved-branch / mispredict statistics counters are enabled by defining BP_STATS_EN.
module branch_predictor #(
    parameter int IDX_BITS = 4,
    parameter int TAG_BITS = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pcF,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_pred_taken,
    input  logic [31:0] upd_pred_target,
    output logic        mispredict,
    output logic [31:0] redirect_pc,
    output logic [31:0] branch_cnt,
    output logic [31:0] mispred_cnt
);

    localparam int ENTRIES = 1 << IDX_BITS;

    logic                validArr  [ENTRIES];
    logic [TAG_BITS-1:0] tagArr    [ENTRIES];
    logic [31:0]         targetArr [ENTRIES];
    logic [1:0]          ctrArr    [ENTRIES];

    logic [IDX_BITS-1:0] fIdx, uIdx;
    logic [TAG_BITS-1:0] fTag, uTag;
    logic                fHit, uHit;

    function automatic logic [1:0] satInc(input logic [1:0] c);
        return (c == 2'b11) ? c : c + 2'b01;
    endfunction

    function automatic logic [1:0] satDec(input logic [1:0] c);
        return (c == 2'b00) ? c : c - 2'b01;
    endfunction

    assign fIdx = pcF[IDX_BITS+1:2];
    assign fTag = pcF[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
    assign uIdx = upd_pc[IDX_BITS+1:2];
    assign uTag = upd_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];

    assign fHit = validArr[fIdx] && (tagArr[fIdx] == fTag);
    assign uHit = validArr[uIdx] && (tagArr[uIdx] == uTag);

    // pcF==0 marks a fetch bubble and must never steer fetch.
    assign pred_taken  = fHit && ctrArr[fIdx][1] && (pcF != 32'd0);
    assign pred_target = pred_taken ? targetArr[fIdx] : pcF + 32'd4;

    assign mispredict = upd_valid &&
                        ((upd_taken != upd_pred_taken) ||
                         (upd_taken && upd_pred_taken && (upd_target != upd_pred_target)));

    // Not-taken recovery skips the delay slot.
    always_comb begin
        redirect_pc = 32'd0;
        if (mispredict)
            redirect_pc = upd_taken ? upd_target : upd_pc + 32'd8;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                validArr[i]  <= 1'b0;
                tagArr[i]    <= '0;
                targetArr[i] <= 32'd0;
                ctrArr[i]    <= 2'b01;
            end
        end else if (upd_valid) begin
            if (uHit) begin
                ctrArr[uIdx] <= upd_taken ? satInc(ctrArr[uIdx]) : satDec(ctrArr[uIdx]);
                if (upd_taken)
                    targetArr[uIdx] <= upd_target;
            end else if (upd_taken) begin
                // Allocation evicts whatever occupied this index.
                validArr[uIdx]  <= 1'b1;
                tagArr[uIdx]    <= uTag;
                targetArr[uIdx] <= upd_target;
                ctrArr[uIdx]    <= 2'b10;
            end
        end
    end

`ifdef BP_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            branch_cnt  <= 32'd0;
            mispred_cnt <= 32'd0;
        end else begin
            if (upd_valid)
                branch_cnt <= branch_cnt + 32'd1;
            if (mispredict)
                mispred_cnt <= mispred_cnt + 32'd1;
        end
    end
`else
    assign branch_cnt  = 32'd0;
    assign mispred_cnt = 32'd0;
`endif

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-stage branch predictor: direct-mapped branch target buffer (BTB) plus a 2-bit saturating direction counter per entry.
- Gives a taken/target prediction for the current fetch PC.
- Takes the resolved outcome of each conditional branch from the decode-stage compare path. On a wrong prediction it raises a same-cycle mispredict with the correct redirect PC.
- Sits between PC select (fetch) and the decode-stage branch compare.

Parameters:
IDX_BITS, 4, log2 of entry count (default 16 entries)
TAG_BITS, 8, stored tag width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
pcF  in  32  fetch-stage PC
pred_taken  out  1  prediction for pcF: taken
pred_target  out  32  predicted next PC for pcF
upd_valid  in  1  decode stage holds a resolved conditional branch this cycle
upd_pc  in  32  PC of that branch
upd_taken  in  1  resolved direction (compare result)
upd_target  in  32  resolved taken target
upd_pred_taken  in  1  pred_taken carried with that branch from fetch
upd_pred_target  in  32  pred_target carried with that branch from fetch
mispredict  out  1  flush/redirect request
redirect_pc  out  32  correct next fetch PC when mispredict=1
branch_cnt  out  32  resolved-branch count (see Optional Feature)
mispred_cnt  out  32  mispredict count (see Optional Feature)

Behaviour:
- Index = pc[IDX_BITS+1:2]. Tag = pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2].
- Per-entry state: valid, tag, target[31:0], ctr[1:0].
- Reset (async, effective immediately): all valid=0, all ctr=2'b01, all targets=0. Outputs settle to pred_taken=0, pred_target=pcF+4, mispredict=0, redirect_pc=0.
- Lookup is combinational from the registered table, 0-cycle latency.
  - hit = valid & tag match.
  - pred_taken = hit & ctr[1] & (pcF != 0). pcF==0 is a pipeline bubble and never predicts taken.
  - pred_target = stored target when pred_taken, else pcF+4.
- Update is on the rising clk edge when upd_valid=1, indexed by upd_pc:
  - Tag hit: ctr saturating +1 if upd_taken, else −1 (saturates at 2'b11 and 2'b00). If upd_taken, target is overwritten with upd_target.
  - Tag miss, upd_taken=1: allocate the entry. valid=1, tag, target=upd_target, ctr=2'b10. The previous occupant is evicted.
  - Tag miss, upd_taken=0: no change.
- upd_valid=0: table unchanged. upd_taken/upd_target are don't-care and may be X.
- Same-cycle lookup and update to the same index: lookup returns the pre-update contents. No bypass.
- Mispredict is combinational: upd_valid & ((upd_taken != upd_pred_taken) | (upd_taken & upd_pred_taken & (upd_target != upd_pred_target))).
- redirect_pc:
  - upd_target if mispredict & upd_taken.
  - upd_pc+8 if mispredict & !upd_taken (falls through past the delay slot).
  - 0 when mispredict=0.
- Reset asserted mid-operation clears all table state. Any in-flight update in that cycle is discarded.

Optional Feature:
- Macro: BP_STATS_EN.
- Defined:
  - branch_cnt increments on every clk edge with upd_valid=1.
  - mispred_cnt increments on every clk edge with mispredict=1.
  - Both are 32-bit, reset to 0, wrap from 0xFFFFFFFF to 0.
- Undefined: both ports are present and tied to 0. No counter registers are inferred.

Test Plan:
1. Reset, then pcF=0x00400010 → pred_taken=0, pred_target=0x00400014. Also present upd_valid=1, upd_pc=0x00400010, upd_taken=1, upd_target=0x00400100, upd_pred_taken=0 → mispredict=1, redirect_pc=0x00400100. After the edge, the same pcF gives pred_taken=1, pred_target=0x00400100 (ctr=2'b10).
2. Same branch resolved not-taken twice with upd_pred_taken=1 → 1st: mispredict=1, redirect_pc=0x00400018, ctr 10→01. 2nd: ctr 01→00, lookup pred_taken=0. Four taken updates then saturate ctr at 11, and a 5th leaves it at 11.
3. Alias: upd_pc=0x00400010 allocated, then 0x00400050 taken (same index, different tag) → entry evicted. Lookup of 0x00400010 gives pred_taken=0, and 0x00400050 hits.
4. Taken hit with upd_pred_target=0x00400100 but upd_target=0x00400200 → mispredict=1, redirect_pc=0x00400200, stored target becomes 0x00400200.
5. pcF=0 with a trained entry at index 0 → pred_taken=0. upd_valid=0 with upd_taken=X → mispredict=0, table unchanged. Reset pulse mid-run → all lookups miss afterward.
6. With BP_STATS_EN: 3 updates, of which 2 mispredict → branch_cnt=3, mispred_cnt=2. Without it, both read 0.
